// File: rtl/multicycle_control.sv
// Multi-cycle main control FSM for the 16-bit RISC core: sequences fetch/decode/
// execute/memory/write-back and drives datapath strobes and mux selects.
module multicycle_control (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [1:0] alu_op,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       ir_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic       i_or_d,
  output logic       mem_to_reg,
  output logic       instr_done,
  output logic       illegal_op,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC_R   = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9
  } state_t;

  typedef enum logic [2:0] {
    C_LW      = 3'd0,
    C_SW      = 3'd1,
    C_RTYPE   = 3'd2,
    C_BRANCH  = 3'd3,
    C_JUMP    = 3'd4,
    C_ILLEGAL = 3'd5
  } op_class_t;

  function automatic op_class_t classify(input logic [3:0] op);
    op_class_t c;
    case (op)
      4'b0000: c = C_LW;
      4'b0001: c = C_SW;
      4'b0010, 4'b0011, 4'b0100, 4'b0101,
      4'b0110, 4'b0111, 4'b1000, 4'b1001: c = C_RTYPE;
      4'b1011, 4'b1100: c = C_BRANCH;
      4'b1101: c = C_JUMP;
      default: c = C_ILLEGAL;
    endcase
    return c;
  endfunction

  state_t    state_r;
  logic      is_bne_r;
  logic      is_sw_r;
  op_class_t op_class_s;

  assign op_class_s = classify(opcode);
  assign state      = state_r;

  // State register; opcode-derived flags are captured only in DECODE so that
  // later IR changes cannot redirect an instruction already in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= S_FETCH;
      is_bne_r <= 1'b0;
      is_sw_r  <= 1'b0;
    end else begin
      case (state_r)
        S_FETCH: begin
          if (mem_ready) state_r <= S_DECODE;
          else           state_r <= S_FETCH;
        end
        S_DECODE: begin
          is_bne_r <= (opcode == 4'b1100);
          is_sw_r  <= (opcode == 4'b0001);
          case (op_class_s)
            C_LW, C_SW: state_r <= S_MEM_ADDR;
            C_RTYPE:    state_r <= S_EXEC_R;
            C_BRANCH:   state_r <= S_BRANCH;
            C_JUMP:     state_r <= S_JUMP;
            default:    state_r <= S_FETCH;
          endcase
        end
        S_MEM_ADDR: begin
          if (is_sw_r) state_r <= S_MEM_WR;
          else         state_r <= S_MEM_RD;
        end
        S_MEM_RD: begin
          if (mem_ready) state_r <= S_MEM_WB;
          else           state_r <= S_MEM_RD;
        end
        S_MEM_WB: state_r <= S_FETCH;
        S_MEM_WR: begin
          if (mem_ready) state_r <= S_FETCH;
          else           state_r <= S_MEM_WR;
        end
        S_EXEC_R: state_r <= S_R_WB;
        S_R_WB:   state_r <= S_FETCH;
        S_BRANCH: state_r <= S_FETCH;
        S_JUMP:   state_r <= S_FETCH;
        default:  state_r <= S_FETCH;
      endcase
    end
  end

  // Output decode; reset overrides everything so no strobe leaks while rst is high.
  always_comb begin
    alu_op     = 2'b10;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    pc_write   = 1'b0;
    pc_src     = 2'b00;
    ir_write   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    i_or_d     = 1'b0;
    mem_to_reg = 1'b0;
    instr_done = 1'b0;
    illegal_op = 1'b0;
    if (rst) begin
      alu_src_b = 2'b01;
    end else begin
      case (state_r)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = 2'b01;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        S_DECODE: begin
          alu_src_b  = 2'b10;
          illegal_op = (op_class_s == C_ILLEGAL);
        end
        S_MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        S_MEM_RD: begin
          mem_read = 1'b1;
          i_or_d   = 1'b1;
        end
        S_MEM_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          instr_done = 1'b1;
        end
        S_MEM_WR: begin
          mem_write  = 1'b1;
          i_or_d     = 1'b1;
          instr_done = mem_ready;
        end
        S_EXEC_R: begin
          alu_src_a = 1'b1;
          alu_op    = 2'b00;
        end
        S_R_WB: begin
          reg_write  = 1'b1;
          instr_done = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a  = 1'b1;
          alu_op     = 2'b01;
          pc_src     = 2'b01;
          pc_write   = zero ^ is_bne_r;
          instr_done = 1'b1;
        end
        S_JUMP: begin
          pc_src     = 2'b10;
          pc_write   = 1'b1;
          instr_done = 1'b1;
        end
        default: begin
          alu_op = 2'b10;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized and directed bench for multicycle_control: each instruction is expanded
// into its expected per-cycle state sequence and output vectors, then compared.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic [1:0] alu_op;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic       pc_write;
  logic [1:0] pc_src;
  logic       ir_write, mem_read, mem_write, reg_write, i_or_d, mem_to_reg;
  logic       instr_done, illegal_op;
  logic [3:0] state;

  int n_assert = 0;
  int n_fail   = 0;

  multicycle_control dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .alu_op(alu_op), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write),
    .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
    .i_or_d(i_or_d), .mem_to_reg(mem_to_reg), .instr_done(instr_done),
    .illegal_op(illegal_op), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic       mr;
    logic       zr;
  } step_t;

  localparam logic [15:0] RESET_VEC = {2'b10, 1'b0, 2'b01, 1'b0, 2'b00, 8'h00};

  function automatic logic [15:0] dut_outs();
    return {alu_op, alu_src_a, alu_src_b, pc_write, pc_src, ir_write, mem_read,
            mem_write, reg_write, i_or_d, mem_to_reg, instr_done, illegal_op};
  endfunction

  // 0 LW, 1 SW, 2 R-type, 3 branch, 4 jump, 5 illegal
  function automatic int op_cls(input logic [3:0] op);
    if (op == 4'd0) return 0;
    if (op == 4'd1) return 1;
    if (op >= 4'd2 && op <= 4'd9) return 2;
    if (op == 4'd11 || op == 4'd12) return 3;
    if (op == 4'd13) return 4;
    return 5;
  endfunction

  function automatic int base_latency(input int c);
    int lat [6] = '{5, 4, 4, 3, 3, 2};
    return lat[c];
  endfunction

  // Expected outputs for one cycle, straight from the per-state rules.
  function automatic logic [15:0] exp_outs(input int st, input logic mr, input logic zr,
                                           input logic bne, input logic [3:0] op);
    logic [1:0] aop = 2'b10, bsel = 2'b00, psrc = 2'b00;
    logic asel = 1'b0, pcw = 1'b0, irw = 1'b0, mrd = 1'b0, mwr = 1'b0, rw = 1'b0;
    logic iod = 1'b0, m2r = 1'b0, done = 1'b0, ill = 1'b0;
    case (st)
      0: begin mrd = 1'b1; bsel = 2'b01; irw = mr; pcw = mr; end
      1: begin bsel = 2'b10; ill = (op_cls(op) == 5); end
      2: begin asel = 1'b1; bsel = 2'b10; end
      3: begin mrd = 1'b1; iod = 1'b1; end
      4: begin rw = 1'b1; m2r = 1'b1; done = 1'b1; end
      5: begin mwr = 1'b1; iod = 1'b1; done = mr; end
      6: begin asel = 1'b1; aop = 2'b00; end
      7: begin rw = 1'b1; done = 1'b1; end
      8: begin asel = 1'b1; aop = 2'b01; psrc = 2'b01; pcw = zr ^ bne; done = 1'b1; end
      9: begin psrc = 2'b10; pcw = 1'b1; done = 1'b1; end
      default: aop = 2'b10;
    endcase
    return {aop, asel, bsel, pcw, psrc, irw, mrd, mwr, rw, iod, m2r, done, ill};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Run one instruction; abort_at >= 0 asserts rst after checking that cycle.
  task automatic run_instr(input logic [3:0] op, input int fst, input int mst,
                           input logic zr, input int abort_at);
    step_t q[$];
    int    c     = op_cls(op);
    logic  bne   = (op == 4'd12);
    int    first = -1;
    int    dones = 0;
    int    ills  = 0;
    int    exp_lat;
    for (int i = 0; i < fst; i++) q.push_back('{4'd0, 1'b0, 1'($urandom)});
    q.push_back('{4'd0, 1'b1, 1'($urandom)});
    q.push_back('{4'd1, 1'($urandom), 1'($urandom)});
    case (c)
      0: begin
        q.push_back('{4'd2, 1'($urandom), 1'($urandom)});
        for (int i = 0; i < mst; i++) q.push_back('{4'd3, 1'b0, 1'($urandom)});
        q.push_back('{4'd3, 1'b1, 1'($urandom)});
        q.push_back('{4'd4, 1'($urandom), 1'($urandom)});
      end
      1: begin
        q.push_back('{4'd2, 1'($urandom), 1'($urandom)});
        for (int i = 0; i < mst; i++) q.push_back('{4'd5, 1'b0, 1'($urandom)});
        q.push_back('{4'd5, 1'b1, 1'($urandom)});
      end
      2: begin
        q.push_back('{4'd6, 1'($urandom), 1'($urandom)});
        q.push_back('{4'd7, 1'($urandom), 1'($urandom)});
      end
      3: q.push_back('{4'd8, 1'($urandom), zr});
      4: q.push_back('{4'd9, 1'($urandom), 1'($urandom)});
      default: ;
    endcase
    exp_lat = base_latency(c) + fst + ((c <= 1) ? mst : 0);

    for (int i = 0; i < q.size(); i++) begin
      @(negedge clk);
      opcode    = (q[i].st == 4'd1) ? op : 4'($urandom);
      mem_ready = q[i].mr;
      zero      = q[i].zr;
      #2;
      chk($sformatf("state op=%0h cyc=%0d", op, i), 32'(state), 32'(q[i].st));
      chk($sformatf("outs op=%0h cyc=%0d st=%0d", op, i, q[i].st), 32'(dut_outs()),
          32'(exp_outs(int'(q[i].st), q[i].mr, q[i].zr, bne, op)));
      if ((instr_done === 1'b1 || illegal_op === 1'b1) && first < 0) first = i;
      if (instr_done === 1'b1) dones++;
      if (illegal_op === 1'b1) ills++;
      if (i == abort_at) begin
        #1 rst = 1'b1;
        #1;
        chk("abort state", 32'(state), 32'd0);
        chk("abort mem_write", 32'(mem_write), 32'd0);
        chk("abort outs", 32'(dut_outs()), 32'(RESET_VEC));
        @(negedge clk);
        rst       = 1'b0;
        mem_ready = 1'b0;
        return;
      end
    end
    chk($sformatf("latency op=%0h", op), 32'(first + 1), 32'(exp_lat));
    chk($sformatf("done count op=%0h", op), 32'(dones), (c == 5) ? 32'd0 : 32'd1);
    chk($sformatf("illegal count op=%0h", op), 32'(ills), (c == 5) ? 32'd1 : 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    opcode    = 4'd0;
    zero      = 1'b0;
    mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    #2;
    chk("reset state", 32'(state), 32'd0);
    chk("reset outs", 32'(dut_outs()), 32'(RESET_VEC));
    @(negedge clk);
    rst       = 1'b0;
    mem_ready = 1'b0;

    run_instr(4'h2, 0, 0, 1'b0, -1);   // ADD
    run_instr(4'h0, 0, 2, 1'b0, -1);   // LW, two stall cycles in MEM_RD
    run_instr(4'hB, 0, 0, 1'b1, -1);   // BEQ taken
    run_instr(4'hC, 0, 0, 1'b1, -1);   // BNE not taken
    run_instr(4'hC, 0, 0, 1'b0, -1);   // BNE taken
    run_instr(4'h1, 0, 0, 1'b0, -1);   // SW
    run_instr(4'hD, 0, 0, 1'b0, -1);   // JMP
    run_instr(4'hF, 0, 0, 1'b0, -1);   // illegal
    run_instr(4'hA, 1, 0, 1'b0, -1);   // illegal, fetch stall
    run_instr(4'hE, 0, 0, 1'b0, -1);   // illegal
    run_instr(4'h1, 0, 2, 1'b0, 3);    // SW aborted by reset during write stall
    run_instr(4'h9, 0, 0, 1'b0, -1);   // fresh SLT after reset

    for (int n = 0; n < 80; n++) begin
      run_instr(4'($urandom), int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                1'($urandom), -1);
    end

    @(negedge clk);
    #2;
    chk("final state", 32'(state), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle main control FSM for the 16-bit RISC core. Sequences each instruction through fetch, decode, execute, memory and write-back states, and drives the datapath strobes and mux selects. It sits directly upstream of `alu_control`, feeding it `alu_op[1:0]`; the 4-bit opcode goes to both blocks from the instruction register. It stalls on a memory ready handshake and flags illegal opcodes.

## Interface
- No parameters; ISA width fixed at 16 bits, opcode 4 bits.
- `clk`  in  1  single system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `opcode`  in  4  instruction[15:12] from the IR; valid from the cycle after `ir_write`.
- `zero`  in  1  ALU zero flag, combinational from the datapath.
- `mem_ready`  in  1  memory completes the current read or write this cycle.
- `alu_op`  out  2  to `alu_control`: 10 = add, 01 = subtract, 00 = function from opcode.
- `alu_src_a`  out  1  0 = PC, 1 = register A.
- `alu_src_b`  out  2  00 = register B, 01 = constant 1, 10 = sign-extended offset.
- `pc_write`  out  1  PC load enable.
- `pc_src`  out  2  00 = ALU result, 01 = ALUOut register, 10 = jump target.
- `ir_write`, `mem_read`, `mem_write`, `reg_write`  out  1 each  strobes.
- `i_or_d`  out  1  memory address select: 0 = PC, 1 = ALUOut.
- `mem_to_reg`  out  1  write-back data select: 1 = MDR, 0 = ALUOut.
- `instr_done`  out  1  one-cycle pulse in the final state of each instruction.
- `illegal_op`  out  1  one-cycle pulse in DECODE for an undefined opcode.
- `state`  out  4  current state encoding, for debug.

## Operation
- Opcodes:
  - 0000 LW, 0001 SW.
  - 0010–1001 R-type (ADD, SUB, INV, LSL, LSR, AND, OR, SLT).
  - 1011 BEQ, 1100 BNE, 1101 JMP.
  - 1010, 1110, 1111 are illegal.
- State encoding:
  - FETCH = 0, DECODE = 1, MEM_ADDR = 2, MEM_RD = 3, MEM_WB = 4.
  - MEM_WR = 5, EXEC_R = 6, R_WB = 7, BRANCH = 8, JUMP = 9.
- FETCH
  - Drives `mem_read`=1, `i_or_d`=0, `alu_src_a`=0, `alu_src_b`=01, `alu_op`=10, `pc_src`=00.
  - `ir_write` = `pc_write` = `mem_ready`.
  - Stays in FETCH while `mem_ready`=0; goes to DECODE when `mem_ready`=1.
- DECODE
  - Computes the branch target: `alu_src_a`=0, `alu_src_b`=10, `alu_op`=10.
  - Registers `is_bne` = (opcode==1100).
  - Next state by opcode: LW/SW → MEM_ADDR; R-type → EXEC_R; BEQ/BNE → BRANCH; JMP → JUMP.
  - Illegal opcode → FETCH with `illegal_op`=1, `instr_done`=0.
- MEM_ADDR: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=10; next MEM_RD for LW, MEM_WR for SW.
- MEM_RD: `mem_read`=1, `i_or_d`=1; waits for `mem_ready`, then MEM_WB.
- MEM_WB: `reg_write`=1, `mem_to_reg`=1, `instr_done`=1; next FETCH.
- MEM_WR
  - `mem_write`=1, `i_or_d`=1; waits for `mem_ready`.
  - On `mem_ready`: `instr_done`=1 and next FETCH.
- EXEC_R: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=00; next R_WB.
- R_WB: `reg_write`=1, `mem_to_reg`=0, `instr_done`=1; next FETCH.
- BRANCH
  - `alu_src_a`=1, `alu_src_b`=00, `alu_op`=01, `pc_src`=01.
  - `pc_write` = `zero` XOR `is_bne`.
  - `instr_done`=1; next FETCH.
- JUMP: `pc_src`=10, `pc_write`=1, `instr_done`=1; next FETCH.
- Unlisted outputs are 0 in every state. `alu_op` is 10 in states that do not use the ALU.
- Outputs are combinational from the registered state, plus `mem_ready` / `zero` where stated above.
- An undefined state encoding returns to FETCH on the next edge.

## Timing
- Reset
  - `rst`=1 forces state=FETCH and `is_bne`=0 asynchronously.
  - While `rst`=1, all strobes are forced to 0: `pc_write`, `ir_write`, `mem_read`, `mem_write`, `reg_write`, `instr_done`, `illegal_op`.
  - While `rst`=1, selects hold FETCH values: `alu_op`=10, `alu_src_b`=01, all other selects 0.
- Reset mid-instruction abandons the instruction. No write strobe is asserted after `rst` rises.
- Latency with `mem_ready` tied to 1:
  - R-type 4 cycles.
  - LW 5 cycles.
  - SW 4 cycles.
  - BEQ/BNE 3 cycles.
  - JMP 3 cycles.
  - Illegal opcode 2 cycles.
- Each cycle of `mem_ready`=0 in FETCH, MEM_RD or MEM_WR adds exactly one cycle.
- The memory strobe stays asserted and the address select stays stable throughout a stall.
- `mem_ready` is ignored in all other states.
- `opcode` is sampled only in DECODE. Changes in other states have no effect.

## Test plan
- Reset with `mem_ready`=1, ADD (0010) → states 0,1,6,7,0:
  - `alu_op`=00 in EXEC_R.
  - `reg_write`=1 only in R_WB.
  - `instr_done` pulses once at cycle 4.
- LW with `mem_ready` low for 2 cycles in MEM_RD → 7 cycles total:
  - `mem_read`=1 and `i_or_d`=1 throughout the stall.
  - `reg_write` with `mem_to_reg`=1 in MEM_WB.
- BEQ with `zero`=1 → `pc_write`=1 and `pc_src`=01 in BRANCH.
  - BNE with `zero`=1 → `pc_write`=0.
  - BNE with `zero`=0 → `pc_write`=1.
  - `alu_op`=01 in all of the above.
- SW, then JMP back-to-back:
  - SW: `mem_write` only in MEM_WR.
  - JMP: `pc_src`=10 and `pc_write`=1 in JUMP.
  - 7 cycles total.
- Opcode 1111 → `illegal_op` pulses in DECODE, next state FETCH, no `reg_write`/`mem_write`/`pc_write` in DECODE.
- Assert `rst` in MEM_WR with `mem_ready`=0:
  - Immediately state=0 and `mem_write`=0.
  - After release, a fresh FETCH proceeds normally.
